// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared widths, address fields and FSM encodings for the data cache controller
package cache_defs;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_W = 64;

  localparam int SET_LO   = 3;
  localparam int SET_HI   = 8;
  localparam int TAG_LO   = 9;
  localparam int TAG_HI   = 18;
  localparam int WORD_SEL = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } cc_state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// rtl/cache_controller_sat_counter.sv - saturating up-counter for cache statistics
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - MEM-stage data cache sequencer: read-miss line fill, write-through with invalidate
module cache_controller
  import cache_defs::*;
#(
  parameter int ADDR_W = cache_defs::ADDR_W,
  parameter int DATA_W = cache_defs::DATA_W,
  parameter int LINE_W = cache_defs::LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ready,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_fill,
  output logic [LINE_W-1:0] cache_fill_line,
  output logic              cache_invalidate,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  cc_state_t state;
  cc_state_t state_nxt;
  logic      hit_inc;
  logic      miss_inc;
  logic      write_addr_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are Mealy; while rst is high everything looks like an idle, request-free cycle
  // so the SRAM side never sees an enable that the same edge is about to cancel.
  always_comb begin
    state_nxt        = state;
    ready            = 1'b1;
    mem_rdata        = '0;
    cache_fill       = 1'b0;
    cache_fill_line  = sram_rdata;
    cache_invalidate = 1'b0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    write_addr_sel   = 1'b0;

    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (mem_w_en) begin
            ready            = 1'b0;
            sram_w_en        = 1'b1;
            cache_invalidate = cache_hit;
            write_addr_sel   = 1'b1;
            state_nxt        = ST_WR_THRU;
          end else if (mem_r_en) begin
            if (cache_hit) begin
              mem_rdata = cache_rdata;
              hit_inc   = 1'b1;
            end else begin
              ready     = 1'b0;
              sram_r_en = 1'b1;
              miss_inc  = 1'b1;
              state_nxt = ST_RD_MISS;
            end
          end
        end

        ST_RD_MISS: begin
          if (sram_ready) begin
            cache_fill = 1'b1;
            mem_rdata  = mem_addr[WORD_SEL] ? sram_rdata[LINE_W-1:DATA_W]
                                            : sram_rdata[DATA_W-1:0];
            state_nxt  = ST_IDLE;
          end else begin
            ready     = 1'b0;
            sram_r_en = 1'b1;
          end
        end

        ST_WR_THRU: begin
          write_addr_sel = 1'b1;
          if (sram_ready) begin
            state_nxt = ST_IDLE;
          end else begin
            ready     = 1'b0;
            sram_w_en = 1'b1;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cache_addr = mem_addr;
  assign sram_wdata = mem_wdata;
  assign sram_addr  = write_addr_sel ? mem_addr : {mem_addr[ADDR_W-1:3], 3'b000};

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_W = 64;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ready;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_fill;
  logic [LINE_W-1:0] cache_fill_line;
  logic              cache_invalidate;
  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
  logic              sram_ready;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  int checks = 0;
  int errors = 0;

  cache_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .ready            (ready),
    .cache_hit        (cache_hit),
    .cache_rdata      (cache_rdata),
    .cache_addr       (cache_addr),
    .cache_fill       (cache_fill),
    .cache_fill_line  (cache_fill_line),
    .cache_invalidate (cache_invalidate),
    .sram_r_en        (sram_r_en),
    .sram_w_en        (sram_w_en),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata),
    .sram_ready       (sram_ready),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    mem_r_en    = 1'b1;
    mem_w_en    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
    sram_rdata  = '0;
    sram_ready  = 1'b0;

    step();
    step();
    sample();
    check("rst_ready", ready, 1);
    check("rst_sram_r_en", sram_r_en, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);

    step();
    rst      = 1'b0;
    mem_addr = 32'h0000_0404;
    sample();
    check("miss_ready0", ready, 0);
    check("miss_sram_r_en", sram_r_en, 1);
    check("miss_sram_addr", sram_addr, 32'h400);
    check("miss_cache_addr", cache_addr, 32'h404);
    for (int i = 1; i < 3; i++) begin
      step();
      sample();
      check("miss_wait_ready", ready, 0);
      check("miss_wait_sram_r_en", sram_r_en, 1);
      check("miss_wait_fill", cache_fill, 0);
    end
    step();
    sram_ready = 1'b1;
    sram_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
    sample();
    check("fill_ready", ready, 1);
    check("fill_rdata", mem_rdata, 32'hBBBB_BBBB);
    check("fill_pulse", cache_fill, 1);
    check("fill_line", cache_fill_line, 64'hBBBB_BBBB_AAAA_AAAA);
    check("fill_sram_r_en", sram_r_en, 0);
    check("fill_miss_count", miss_count, 1);

    step();
    sram_ready  = 1'b0;
    cache_hit   = 1'b1;
    cache_rdata = 32'hBBBB_BBBB;
    sample();
    check("hit_ready", ready, 1);
    check("hit_rdata", mem_rdata, 32'hBBBB_BBBB);
    check("hit_fill", cache_fill, 0);
    check("hit_sram_r_en", sram_r_en, 0);
    step();
    mem_r_en  = 1'b0;
    cache_hit = 1'b0;
    sample();
    check("cnt_hit", hit_count, 1);
    check("cnt_miss", miss_count, 1);
    check("idle_rdata", mem_rdata, 0);

    step();
    mem_w_en  = 1'b1;
    mem_addr  = 32'h0000_0408;
    mem_wdata = 32'h0000_1234;
    cache_hit = 1'b1;
    sample();
    check("wr_inval", cache_invalidate, 1);
    check("wr_ready", ready, 0);
    check("wr_sram_w_en", sram_w_en, 1);
    check("wr_sram_addr", sram_addr, 32'h408);
    check("wr_sram_wdata", sram_wdata, 32'h1234);
    step();
    sample();
    check("wr_inval_once", cache_invalidate, 0);
    check("wr_hold_w_en", sram_w_en, 1);
    check("wr_hold_ready", ready, 0);
    step();
    sram_ready = 1'b1;
    sample();
    check("wr_done_ready", ready, 1);
    check("wr_done_w_en", sram_w_en, 0);
    check("wr_done_fill", cache_fill, 0);
    step();
    sram_ready = 1'b0;
    mem_w_en   = 1'b0;
    cache_hit  = 1'b0;
    sample();
    check("wr_idle_ready", ready, 1);
    check("wr_idle_w_en", sram_w_en, 0);

    step();
    mem_r_en = 1'b1;
    mem_w_en = 1'b1;
    mem_addr = 32'h0000_0500;
    sample();
    check("both_w_en", sram_w_en, 1);
    check("both_r_en", sram_r_en, 0);
    check("both_ready", ready, 0);
    step();
    sram_ready = 1'b1;
    sample();
    check("both_done_ready", ready, 1);
    step();
    sram_ready = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    sample();
    check("both_miss_count", miss_count, 1);

    step();
    mem_r_en = 1'b1;
    mem_addr = 32'h0000_0600;
    sample();
    check("rmid_r_en", sram_r_en, 1);
    step();
    sample();
    check("rmid_wait1", sram_r_en, 1);
    step();
    rst = 1'b1;
    sample();
    check("rmid_rst_r_en", sram_r_en, 0);
    step();
    rst        = 1'b0;
    mem_r_en   = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = 64'h1111_1111_2222_2222;
    sample();
    check("rmid_idle_r_en", sram_r_en, 0);
    check("rmid_no_fill", cache_fill, 0);
    check("rmid_ready", ready, 1);
    check("rmid_miss_cleared", miss_count, 0);

    step();
    sram_ready  = 1'b0;
    mem_r_en    = 1'b1;
    cache_hit   = 1'b1;
    cache_rdata = 32'hCAFE_F00D;
    mem_addr    = 32'h0000_0404;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    mem_r_en  = 1'b0;
    cache_hit = 1'b0;
    sample();
    check("sat_hit", hit_count, 15);
    check("sat_miss", miss_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
